// File: rtl/key_debouncer_pkg.sv
// io_pkg: definitions shared by the board-I/O blocks (key debouncer and
// sample tick divider).
//   key_state_t     - per-key debounce FSM states
//   count_width()   - bits needed to hold the values 0..max_count
//   DEFAULT_*       - default sample rate and stability window
package io_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  localparam int DEFAULT_SAMPLE_HZ      = 1000;
  localparam int DEFAULT_STABLE_SAMPLES = 20;

  // Width of a counter that must reach max_count; never less than one bit.
  function automatic int count_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debouncer_sample_tick_gen.sv
// sample_tick_gen: free-running divider producing a one-clock strobe every
// DIV clocks. The first strobe appears DIV cycles after reset is released.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   sample_tick  out  high while the divider sits at DIV-1
module sample_tick_gen
  import io_pkg::*;
#(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  output logic sample_tick
);

  localparam int CW = count_width(DIV - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Decoded from a register, so the strobe is glitch-free and one clock wide.
  assign sample_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: synchronises NUM_KEYS raw board keys, debounces each one on
// a divided sample tick and publishes a clean level plus one-clock
// press/release pulses.
// Optional feature (macro KEY_LONG_PRESS_EN): adds parameter LONG_SAMPLES and
// output key_long, a one-clock pulse once a key has been held LONG_SAMPLES
// ticks after its press was accepted (at most once per press).
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   key_in       in   raw asynchronous key pins
//   key_level    out  debounced level, 1 = pressed
//   key_press    out  one-clock pulse on an accepted 0->1
//   key_release  out  one-clock pulse on an accepted 1->0
//   key_long     out  one-clock long-hold pulse (KEY_LONG_PRESS_EN only)
//   sample_tick  out  debounce sample strobe, every DIV clocks
module key_debouncer
  import io_pkg::*;
#(
  parameter int NUM_KEYS       = 5,
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int SAMPLE_HZ      = DEFAULT_SAMPLE_HZ,
  parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
  parameter int KEY_ACTIVE_LOW = 0
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int LONG_SAMPLES   = 1000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
`ifdef KEY_LONG_PRESS_EN
  output logic [NUM_KEYS-1:0] key_long,
`endif
  output logic                sample_tick
);

  localparam int DIV = CLK_FREQ_HZ / SAMPLE_HZ;
  localparam int CW  = count_width(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync_out;
  logic [NUM_KEYS-1:0] s;

  sample_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick)
  );

  // Two-flop synchroniser per key; the first stage may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= key_in;
      sync_out  <= sync_meta;
    end
  end

  // Normalise polarity so that 1 always means pressed from here on.
  assign s = (KEY_ACTIVE_LOW != 0) ? ~sync_out : sync_out;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_state_t    state;
    key_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_q;
    logic          level_next;
    logic          press_q;
    logic          press_next;
    logic          release_q;
    logic          release_next;

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= RELEASED;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_next;
        cnt       <= cnt_next;
        level_q   <= level_next;
        press_q   <= press_next;
        release_q <= release_next;
      end
    end

    // The FSM only advances on sample ticks. The CHK states count agreeing
    // samples; a single disagreeing sample drops back to the stable state.
    // With a one-sample window the CHK states are skipped entirely.
    always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      level_next   = level_q;
      press_next   = 1'b0;
      release_next = 1'b0;
      if (sample_tick) begin
        unique case (state)
          RELEASED: begin
            if (s[i]) begin
              if (STABLE_SAMPLES == 1) begin
                state_next = PRESSED;
                level_next = 1'b1;
                press_next = 1'b1;
              end else begin
                state_next = PRESS_CHK;
                cnt_next   = CW'(1);
              end
            end
          end
          PRESS_CHK: begin
            if (!s[i]) begin
              state_next = RELEASED;
              cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
              state_next = PRESSED;
              cnt_next   = '0;
              level_next = 1'b1;
              press_next = 1'b1;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
          PRESSED: begin
            if (!s[i]) begin
              if (STABLE_SAMPLES == 1) begin
                state_next   = RELEASED;
                level_next   = 1'b0;
                release_next = 1'b1;
              end else begin
                state_next = RELEASE_CHK;
                cnt_next   = CW'(1);
              end
            end
          end
          RELEASE_CHK: begin
            if (s[i]) begin
              state_next = PRESSED;
              cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
              state_next   = RELEASED;
              cnt_next     = '0;
              level_next   = 1'b0;
              release_next = 1'b1;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
          default: begin
            state_next = RELEASED;
            cnt_next   = '0;
          end
        endcase
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int HW = count_width(LONG_SAMPLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_SAMPLES - 1);

    logic [HW-1:0] hold;
    logic [HW-1:0] hold_next;
    logic          long_done;
    logic          long_done_next;
    logic          long_q;
    logic          long_next;

    always_ff @(posedge clk) begin
      if (rst) begin
        hold      <= '0;
        long_done <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        hold      <= hold_next;
        long_done <= long_done_next;
        long_q    <= long_next;
      end
    end

    // The hold counter saturates at LONG_SAMPLES-1. long_done survives a
    // bounce through RELEASE_CHK so a single press never fires twice; it is
    // only cleared once the release is actually accepted.
    always_comb begin
      hold_next      = hold;
      long_done_next = long_done;
      long_next      = 1'b0;
      if (sample_tick) begin
        if (state == PRESSED && state_next == PRESSED) begin
          if (hold == HOLD_LAST) begin
            if (!long_done) begin
              long_next      = 1'b1;
              long_done_next = 1'b1;
            end
          end else begin
            hold_next = hold + HW'(1);
          end
        end else if (state == PRESSED) begin
          hold_next = '0;
        end
        if (state_next == RELEASED) begin
          long_done_next = 1'b0;
        end
      end
    end

    assign key_long[i] = long_q;
`endif
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer with DIV=10, STABLE_SAMPLES=4, NUM_KEYS=2.
// Two instances see the same logical keys: dut_a is active-high and dut_b is
// active-low, driven with the inverted pins, so both must behave the same.
// Long-press checks run only when KEY_LONG_PRESS_EN is defined.
module tb_key_debouncer;

  localparam int NK     = 2;
  localparam int DIV    = 10;
  localparam int STABLE = 4;
  localparam int LONG   = 6;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_in_n;
  logic [NK-1:0] level_a, press_a, release_a, long_a;
  logic [NK-1:0] level_b, press_b, release_b, long_b;
  logic          tick_a, tick_b;

  int checks = 0;
  int errors = 0;

  assign key_in_n = ~key_in;

  always #5 clk = ~clk;

  key_debouncer #(
    .NUM_KEYS(NK), .CLK_FREQ_HZ(1000), .SAMPLE_HZ(100),
    .STABLE_SAMPLES(STABLE), .KEY_ACTIVE_LOW(0)
`ifdef KEY_LONG_PRESS_EN
    , .LONG_SAMPLES(LONG)
`endif
  ) dut_a (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(level_a), .key_press(press_a), .key_release(release_a),
`ifdef KEY_LONG_PRESS_EN
    .key_long(long_a),
`endif
    .sample_tick(tick_a)
  );

  key_debouncer #(
    .NUM_KEYS(NK), .CLK_FREQ_HZ(1000), .SAMPLE_HZ(100),
    .STABLE_SAMPLES(STABLE), .KEY_ACTIVE_LOW(1)
`ifdef KEY_LONG_PRESS_EN
    , .LONG_SAMPLES(LONG)
`endif
  ) dut_b (
    .clk(clk), .rst(rst), .key_in(key_in_n),
    .key_level(level_b), .key_press(press_b), .key_release(release_b),
`ifdef KEY_LONG_PRESS_EN
    .key_long(long_b),
`endif
    .sample_tick(tick_b)
  );

`ifndef KEY_LONG_PRESS_EN
  assign long_a = '0;
  assign long_b = '0;
`endif

  // Reference model: a key flips its accepted level once STABLE consecutive
  // ticks have seen the opposite value; any agreeing tick restarts the run.
  // Long press: ticks held since acceptance (or since the last bounce).
  typedef struct packed {
    logic [31:0]        cyc;
    logic [NK-1:0]      s1, s2, level, press, rel, lng, done;
    logic [NK-1:0][7:0] run, hold;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic [NK-1:0] pins, logic rst_in);
    model_t n;
    logic   tick;
    n       = cur;
    n.press = '0;
    n.rel   = '0;
    n.lng   = '0;
    if (rst_in) begin
      n = '0;
      return n;
    end
    tick = ((cur.cyc % DIV) == DIV - 1);
    if (tick) begin
      for (int k = 0; k < NK; k++) begin
        logic sv;
        sv = cur.s2[k];
        if (cur.level[k]) begin
          if (sv && cur.run[k] == 0) begin
            if (cur.hold[k] < LONG) n.hold[k] = cur.hold[k] + 8'd1;
            if (n.hold[k] == LONG && !cur.done[k]) begin
              n.lng[k]  = 1'b1;
              n.done[k] = 1'b1;
            end
          end else begin
            n.hold[k] = '0;
          end
        end
        if (sv != cur.level[k]) begin
          n.run[k] = cur.run[k] + 8'd1;
          if (n.run[k] == STABLE) begin
            n.level[k] = sv;
            n.run[k]   = '0;
            if (sv) begin
              n.press[k] = 1'b1;
            end else begin
              n.rel[k]  = 1'b1;
              n.done[k] = 1'b0;
            end
          end
        end else begin
          n.run[k] = '0;
        end
      end
    end
    n.s2  = cur.s1;
    n.s1  = pins;
    n.cyc = cur.cyc + 32'd1;
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, key_in, rst);

  function automatic logic exp_tick();
    return ((m.cyc % DIV) == DIV - 1);
  endfunction

  function automatic logic [31:0] expected_vec();
    logic [8:0] one;
    one = {exp_tick(), m.level, m.press, m.rel, m.lng & {NK{LONG_EN}}};
    return {14'd0, one, one};
  endfunction

  function automatic logic [31:0] observed_vec();
    return {14'd0, tick_a, level_a, press_a, release_a, long_a,
            tick_b, level_b, press_b, release_b, long_b};
  endfunction

  task automatic applyStimulus(input logic [NK-1:0] keys);
    key_in = keys;
  endtask

  task automatic test_reset();
    int first_tick = -1;
    int tick_cnt   = 0;
    rst = 1'b1;
    applyStimulus('0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      if (tick_a && first_tick < 0) first_tick = i;
      if (tick_a) tick_cnt++;
    end
    checks++;
    if (first_tick !== 9) begin
      errors++;
      $display("[TB] FAIL first_tick: observed %0d expected 9", first_tick);
    end
    checks++;
    if (tick_cnt !== 3) begin
      errors++;
      $display("[TB] FAIL tick_count: observed %0d expected 3", tick_cnt);
    end
  endtask

  task automatic test_clean_press();
    int presses  = 0;
    int releases = 0;
    applyStimulus(2'b01);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL clean_press cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      presses  += int'(press_a[0]);
      releases += int'(release_a[0]);
    end
    checks++;
    if (presses !== 1 || releases !== 0 || level_a !== 2'b01) begin
      errors++;
      $display("[TB] FAIL clean_press_summary: observed press=%0d release=%0d level=%b expected 1 0 01",
               presses, releases, level_a);
    end
    applyStimulus(2'b00);
    releases = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL clean_release cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      releases += int'(release_a[0]);
    end
    checks++;
    if (releases !== 1 || level_a !== 2'b00) begin
      errors++;
      $display("[TB] FAIL clean_release_summary: observed release=%0d level=%b expected 1 00", releases, level_a);
    end
  endtask

  task automatic test_bounce();
    int bounce_presses = 0;
    int steady_presses = 0;
    applyStimulus(2'b00);
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 0) key_in[0] = ~key_in[0];
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL bounce cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      bounce_presses += int'(press_a[0]) + int'(release_a[0]);
    end
    applyStimulus(2'b01);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL bounce_settle cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      steady_presses += int'(press_a[0]);
    end
    checks++;
    if (bounce_presses !== 0 || steady_presses !== 1) begin
      errors++;
      $display("[TB] FAIL bounce_summary: observed bounce=%0d settle=%0d expected 0 1", bounce_presses, steady_presses);
    end
    applyStimulus(2'b00);
    repeat (60) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int            press_cycles = 0;
    int            rel_cycles   = 0;
    logic [NK-1:0] press_val    = '0;
    logic [NK-1:0] rel_val      = '0;
    applyStimulus(2'b11);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL simul_press cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      if (press_a != '0) begin
        press_cycles++;
        press_val = press_a;
      end
    end
    checks++;
    if (press_cycles !== 1 || press_val !== 2'b11) begin
      errors++;
      $display("[TB] FAIL simul_press_summary: observed cycles=%0d value=%b expected 1 11", press_cycles, press_val);
    end
    applyStimulus(2'b01);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL simul_release cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      if (release_a != '0) begin
        rel_cycles++;
        rel_val = release_a;
      end
    end
    checks++;
    if (rel_cycles !== 1 || rel_val !== 2'b10 || level_a !== 2'b01) begin
      errors++;
      $display("[TB] FAIL simul_release_summary: observed cycles=%0d value=%b level=%b expected 1 10 01",
               rel_cycles, rel_val, level_a);
    end
    applyStimulus(2'b00);
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce();
    int seen  = 0;
    int n     = 0;
    int idx_a = -1;
    int idx_b = -1;
    applyStimulus(2'b01);
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL mid_debounce cycle %0d: observed %h expected %h", n, observed_vec(), expected_vec());
      end
      if (n >= 1 && exp_tick()) seen++;
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec() || level_a !== 1'b0 || press_b !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_reset cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL after_reset cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      if (press_a[0] && idx_a < 0) idx_a = i;
      if (press_b[0] && idx_b < 0) idx_b = i;
    end
    checks++;
    if (idx_a !== 40 || idx_b !== 40) begin
      errors++;
      $display("[TB] FAIL press_after_reset: observed a=%0d b=%0d expected 40 40", idx_a, idx_b);
    end
    applyStimulus(2'b00);
    repeat (60) @(negedge clk);
  endtask

  task automatic test_random();
    int dwell [NK];
    for (int k = 0; k < NK; k++) dwell[k] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (dwell[k] == 0) begin
          key_in[k] = ~key_in[k];
          dwell[k]  = $urandom_range(1, 60);
        end else begin
          dwell[k]--;
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
    end
    rst = 1'b0;
    applyStimulus(2'b00);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL random_drain cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
    end
  endtask

`ifdef KEY_LONG_PRESS_EN
  task automatic test_long_press();
    int press_idx = -1;
    int long_idx  = -1;
    int longs     = 0;
    int n         = 0;
    applyStimulus(2'b01);
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL long_hold cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      if (press_a[0] && press_idx < 0) press_idx = i;
      if (long_a[0]) begin
        longs++;
        long_idx = i;
      end
    end
    checks++;
    if (longs !== 1 || press_idx < 0 || (long_idx - press_idx) !== 60) begin
      errors++;
      $display("[TB] FAIL long_pulse: observed count=%0d delay=%0d expected 1 60", longs, long_idx - press_idx);
    end
    applyStimulus(2'b00);
    repeat (60) @(negedge clk);
    longs = 0;
    press_idx = -1;
    applyStimulus(2'b01);
    while (press_idx < 0 && n < 100) begin
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL short_hold cycle %0d: observed %h expected %h", n, observed_vec(), expected_vec());
      end
      if (press_a[0]) press_idx = n;
      n++;
    end
    checks++;
    if (press_idx < 0) begin
      errors++;
      $display("[TB] FAIL short_press_timeout: observed no press within 100 cycles expected one");
    end
    for (int i = 0; i < 105; i++) begin
      if (i == 25) applyStimulus(2'b00);
      @(negedge clk);
      checks++;
      if (observed_vec() !== expected_vec()) begin
        errors++;
        $display("[TB] FAIL short_release cycle %0d: observed %h expected %h", i, observed_vec(), expected_vec());
      end
      longs += int'(long_a[0]) + int'(long_b[0]);
    end
    checks++;
    if (longs !== 0) begin
      errors++;
      $display("[TB] FAIL short_no_long: observed %0d expected 0", longs);
    end
  endtask
`endif

  initial begin
    rst    = 1'b1;
    key_in = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
`ifdef KEY_LONG_PRESS_EN
    test_long_press();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Input-side counterpart to the slow-clock generator.
- Takes N raw, asynchronous board push-buttons or switches and synchronises each to clk.
- Debounces each key on a divided sample tick and publishes a clean level plus one-cycle press/release pulses.
- Sits between the board I/O pins and the CPU I/O/MMIO logic.

Parameters:
- NUM_KEYS, 5: number of independent key inputs.
- CLK_FREQ_HZ, 100_000_000: clk frequency.
- SAMPLE_HZ, 1000: debounce sample-tick rate. DIV = CLK_FREQ_HZ/SAMPLE_HZ, integer, must be ≥2.
- STABLE_SAMPLES, 20: consecutive agreeing ticks needed to accept a new level. Must be ≥1.
- KEY_ACTIVE_LOW, 0: 1 inverts key_in after synchronisation, so "pressed" is always 1 internally.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_in  in  NUM_KEYS  raw asynchronous key pins.
- key_level  out  NUM_KEYS  debounced level, 1 = pressed.
- key_press  out  NUM_KEYS  one-clk pulse on accepted 0→1.
- key_release  out  NUM_KEYS  one-clk pulse on accepted 1→0.
- sample_tick  out  1  one-clk strobe every DIV cycles, exported for observability.

Behaviour:
- Reset: single clock, no internal clock enables other than sample_tick. When rst=1 at a clk edge, all outputs, sync flops, divider and per-key counters go to 0 and every key FSM goes to RELEASED.
- Synchroniser: two-flop chain per key, then optional inversion, giving s[i]. Raw-to-s latency is 2 clk.
- Divider: counter 0..DIV-1, increments every clk and wraps to 0. sample_tick=1 in the cycle the counter equals DIV-1, so the first tick occurs DIV cycles after reset release.
- Per-key FSM, evaluated only when sample_tick=1; otherwise state and counter hold:
  - RELEASED: if s=1, cnt←1 and go to PRESS_CHK. If STABLE_SAMPLES=1, instead go straight to PRESSED with a press pulse.
  - PRESS_CHK: if s=0, cnt←0 and go to RELEASED (bounce rejected). Else if cnt=STABLE_SAMPLES-1, go to PRESSED: key_level←1, key_press=1 for that cycle only. Else cnt←cnt+1.
  - PRESSED: mirror of RELEASED, towards RELEASE_CHK.
  - RELEASE_CHK: mirror of PRESS_CHK. Acceptance sets key_level←0 and pulses key_release.
- key_level is registered and changes in the same cycle as the pulse. Pulses are registered, exactly one clk wide, and never both high for one key.
- Latency: a clean edge is accepted on the STABLE_SAMPLES-th tick that samples the new level, i.e. (STABLE_SAMPLES-1)·DIV+≤DIV cycles after s changes.
- cnt width is clog2(STABLE_SAMPLES+1) and never exceeds STABLE_SAMPLES-1.
- Keys are fully independent. Simultaneous accepts on several keys all pulse in the same cycle.
- Reset mid-debounce discards partial counts, and no pulse is emitted. A key held through reset produces a press after a full debounce once rst drops.

Optional Feature:
- Macro KEY_LONG_PRESS_EN.
- Defined:
  - Adds parameter LONG_SAMPLES (default 1000) and output key_long [NUM_KEYS].
  - In PRESSED, a per-key hold counter increments per tick.
  - key_long pulses one clk when the counter reaches LONG_SAMPLES-1, at most once per press.
  - The hold counter clears on leaving PRESSED and on rst.
- Undefined: port, parameter and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package io_pkg holds:
  - the state typedef (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK);
  - the clog2-based width function;
  - default SAMPLE_HZ/STABLE_SAMPLES constants.
- One natural sub-module: sample_tick_gen, parameterised divider producing sample_tick. It is reusable by the slow-clock logic; key_debouncer instantiates it once and generates NUM_KEYS FSM instances.

Test Plan (CLK_FREQ_HZ=1000, SAMPLE_HZ=100 → DIV=10, STABLE_SAMPLES=4, NUM_KEYS=2):
- Reset release, inputs low → sample_tick first at cycle 10 then every 10; all outputs 0 throughout.
- key_in[0] rises clean and stays → key_press[0] single pulse with key_level[0]=1 on the 4th tick seeing s=1; no key_release.
- key_in[0] toggles every 7 cycles for 60 cycles, then steady 1 → no pulse during bouncing; exactly one press once 4 consecutive ticks agree.
- Both keys rise on the same cycle → key_press=2'b11 in one cycle. Later release of key 1 only → key_release=2'b10, key_level=2'b01.
- rst asserted after 2 agreeing ticks with key held → outputs 0 during reset; press pulses 4 ticks after rst deasserts. With KEY_ACTIVE_LOW=1, a held-low pin gives the same result.
- KEY_LONG_PRESS_EN with LONG_SAMPLES=6, held 20 ticks → one key_long pulse 6 ticks after press accept; released early at 3 ticks → no key_long.
